// File: rtl/cis_line_sequencer_pkg.sv
// Shared types and constants for the CIS line sequencer: FSM state encoding,
// one-hot colour selects and the default counter width.
package cis_line_sequencer_pkg;

  localparam int CIS_CNT_W = 32;

  localparam logic [2:0] RGB_NONE = 3'b000;
  localparam logic [2:0] RGB_R    = 3'b100;
  localparam logic [2:0] RGB_G    = 3'b010;
  localparam logic [2:0] RGB_B    = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SETUP,
    ST_EXPOSE,
    ST_GAP
  } state_t;

endpackage

// File: rtl/cis_color_ptr.sv
// Picks the next enabled colour after the current one in R, G, B order.
// A current colour of 000 means "start of line" and yields the first enabled colour.
module cis_color_ptr
  import cis_line_sequencer_pkg::*;
(
  input  logic [2:0] mask_i,
  input  logic [2:0] cur_i,
  output logic [2:0] nxt_o,
  output logic       last_o
);

  logic [2:0] after;

  always_comb begin
    after = mask_i;
    unique case (cur_i)
      RGB_R:   after = mask_i & (RGB_G | RGB_B);
      RGB_G:   after = mask_i & RGB_B;
      RGB_B:   after = RGB_NONE;
      default: after = mask_i;
    endcase

    nxt_o = RGB_NONE;
    if ((after & RGB_R) != RGB_NONE)      nxt_o = RGB_R;
    else if ((after & RGB_G) != RGB_NONE) nxt_o = RGB_G;
    else if ((after & RGB_B) != RGB_NONE) nxt_o = RGB_B;

    last_o = (after == RGB_NONE);
  end

endmodule

// File: rtl/cis_line_sequencer.sv
// Per-line R/G/B slot sequencer for the contact-image-sensor front end.
// Outputs are registered so each output value lines up with the state it describes.
module cis_line_sequencer
  import cis_line_sequencer_pkg::*;
#(
  parameter int CNT_W  = CIS_CNT_W,
  parameter int LCNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ENABLE,
  input  logic              FREE_RUN,
  input  logic              TRIG,
  input  logic [2:0]        COLOR_MASK,
  input  logic [CNT_W-1:0]  SLOT_LEN,
  input  logic [CNT_W-1:0]  EXP_LEN,
  output logic              START,
  output logic              END,
  output logic [2:0]        RGB,
  output logic              SI,
  output logic              LINE_DONE,
  output logic              BUSY,
  output logic              OVERRUN,
  output logic [LCNT_W-1:0] LINE_CNT
);

  state_t              state_q, state_d;
  logic [CNT_W:0]      cnt_q, cnt_d;
  logic [2:0]          col_q, col_d;
  logic [2:0]          mask_s_q, mask_s_d;
  logic [CNT_W-1:0]    slot_s_q, slot_s_d;
  logic [CNT_W-1:0]    exp_s_q, exp_s_d;
  logic                pend_q, pend_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic                start_q, start_d;
  logic                end_q, end_d;
  logic [2:0]          rgb_q, rgb_d;
  logic                si_q, si_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ovr_q, ovr_d;

  logic [2:0]          ptr_mask, ptr_cur, ptr_nxt;
  logic                ptr_last;
  logic [CNT_W:0]      exp_p2, slot_ext, slot_m1;
  logic                slot_last, exp_hit, exp_zero, launch, adv;

  // In ARM the pointer looks at the live mask to find the first colour;
  // mid-line it walks the shadow mask captured at launch.
  assign ptr_mask = (state_q == ST_ARM) ? COLOR_MASK : mask_s_q;
  assign ptr_cur  = (state_q == ST_ARM) ? RGB_NONE   : col_q;

  cis_color_ptr u_ptr (
    .mask_i (ptr_mask),
    .cur_i  (ptr_cur),
    .nxt_o  (ptr_nxt),
    .last_o (ptr_last)
  );

  // Slot length is stretched to EXP_LEN+2 so SETUP, START..END always fit.
  assign exp_p2    = {1'b0, exp_s_q} + (CNT_W+1)'(2);
  assign slot_ext  = {1'b0, slot_s_q};
  assign slot_m1   = ((slot_ext > exp_p2) ? slot_ext : exp_p2) - (CNT_W+1)'(1);
  assign slot_last = (cnt_q == slot_m1);
  assign exp_hit   = (cnt_q == {1'b0, exp_s_q});
  assign exp_zero  = (exp_s_q == '0);
  assign launch    = (COLOR_MASK != RGB_NONE) && (FREE_RUN || pend_q || TRIG);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + (CNT_W+1)'(1);
    col_d    = col_q;
    mask_s_d = mask_s_q;
    slot_s_d = slot_s_q;
    exp_s_d  = exp_s_q;
    pend_d   = pend_q;
    lcnt_d   = lcnt_q;
    start_d  = 1'b0;
    end_d    = 1'b0;
    rgb_d    = RGB_NONE;
    si_d     = 1'b0;
    done_d   = 1'b0;
    busy_d   = 1'b0;
    ovr_d    = 1'b0;
    adv      = 1'b0;

    if (TRIG && busy_q) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end

    if (!ENABLE) begin
      // Abort: close an open exposure window, drop the line without LINE_DONE.
      state_d = ST_IDLE;
      pend_d  = 1'b0;
      col_d   = RGB_NONE;
      end_d   = (state_q == ST_EXPOSE) && !end_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          pend_d  = 1'b0;
        end
        ST_ARM: begin
          if (launch) begin
            state_d  = ST_SETUP;
            mask_s_d = COLOR_MASK;
            slot_s_d = SLOT_LEN;
            exp_s_d  = EXP_LEN;
            col_d    = ptr_nxt;
            rgb_d    = ptr_nxt;
            si_d     = 1'b1;
            busy_d   = 1'b1;
            cnt_d    = '0;
            pend_d   = pend_q & TRIG;
            ovr_d    = 1'b0;
          end
        end
        ST_SETUP: begin
          busy_d = 1'b1;
          rgb_d  = col_q;
          if (exp_zero) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_EXPOSE;
            start_d = 1'b1;
          end
        end
        ST_EXPOSE: begin
          busy_d = 1'b1;
          rgb_d  = col_q;
          if (slot_last)  adv     = 1'b1;
          else if (end_q) state_d = ST_GAP;
          else            end_d   = exp_hit;
        end
        ST_GAP: begin
          busy_d = 1'b1;
          rgb_d  = col_q;
          if (slot_last) adv = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase

      if (adv) begin
        cnt_d  = '0;
        busy_d = 1'b1;
        if (ptr_last) begin
          state_d = ST_ARM;
          col_d   = RGB_NONE;
          rgb_d   = RGB_NONE;
          done_d  = 1'b1;
          lcnt_d  = lcnt_q + LCNT_W'(1);
        end else begin
          state_d = ST_SETUP;
          col_d   = ptr_nxt;
          rgb_d   = ptr_nxt;
          si_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      col_q    <= RGB_NONE;
      mask_s_q <= RGB_NONE;
      slot_s_q <= '0;
      exp_s_q  <= '0;
      pend_q   <= 1'b0;
      lcnt_q   <= '0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      rgb_q    <= RGB_NONE;
      si_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      mask_s_q <= mask_s_d;
      slot_s_q <= slot_s_d;
      exp_s_q  <= exp_s_d;
      pend_q   <= pend_d;
      lcnt_q   <= lcnt_d;
      start_q  <= start_d;
      end_q    <= end_d;
      rgb_q    <= rgb_d;
      si_q     <= si_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  end

  assign START     = start_q;
  assign END       = end_q;
  assign RGB       = rgb_q;
  assign SI        = si_q;
  assign LINE_DONE = done_q;
  assign BUSY      = busy_q;
  assign OVERRUN   = ovr_q;
  assign LINE_CNT  = lcnt_q;

endmodule

// File: tb/tb_cis_line_sequencer.sv
// Directed bench for cis_line_sequencer: table-driven line timing plus
// hand-written sequences for clamping, abort, reset and mask shadowing.
module tb_cis_line_sequencer;

  localparam int CNT_W  = 32;
  localparam int LCNT_W = 16;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              ENABLE;
  logic              FREE_RUN;
  logic              TRIG;
  logic [2:0]        COLOR_MASK;
  logic [CNT_W-1:0]  SLOT_LEN;
  logic [CNT_W-1:0]  EXP_LEN;
  logic              START;
  logic              END;
  logic [2:0]        RGB;
  logic              SI;
  logic              LINE_DONE;
  logic              BUSY;
  logic              OVERRUN;
  logic [LCNT_W-1:0] LINE_CNT;

  always #5 CLK = ~CLK;

  cis_line_sequencer #(.CNT_W(CNT_W), .LCNT_W(LCNT_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ENABLE     (ENABLE),
    .FREE_RUN   (FREE_RUN),
    .TRIG       (TRIG),
    .COLOR_MASK (COLOR_MASK),
    .SLOT_LEN   (SLOT_LEN),
    .EXP_LEN    (EXP_LEN),
    .START      (START),
    .END        (END),
    .RGB        (RGB),
    .SI         (SI),
    .LINE_DONE  (LINE_DONE),
    .BUSY       (BUSY),
    .OVERRUN    (OVERRUN),
    .LINE_CNT   (LINE_CNT)
  );

  typedef struct {
    int          t;
    logic        trig;
    logic [2:0]  rgb;
    logic        si, st, en, dn, by, ov;
    logic [15:0] lc;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [24:0] obs();
    return {RGB, SI, START, END, LINE_DONE, BUSY, OVERRUN, LINE_CNT};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int t, input logic trig, input logic [2:0] rgb,
                     input logic si, input logic st, input logic en, input logic dn,
                     input logic by, input logic ov, input logic [15:0] lc);
    vec_t v;
    v.t = t; v.trig = trig; v.rgb = rgb; v.si = si; v.st = st; v.en = en;
    v.dn = dn; v.by = by; v.ov = ov; v.lc = lc;
    vq.push_back(v);
  endtask

  // Rows are sampled at the negedge labelled t, then the row's TRIG is driven.
  task automatic run_seg(input string name, input int first, input int last);
    int idx = first;
    int t   = 0;
    while (idx <= last) begin
      if (vq[idx].t == t) begin
        check($sformatf("%s_t%0d", name, t), 64'(obs()),
              64'({vq[idx].rgb, vq[idx].si, vq[idx].st, vq[idx].en,
                   vq[idx].dn, vq[idx].by, vq[idx].ov, vq[idx].lc}));
        TRIG = vq[idx].trig;
        idx++;
      end else begin
        TRIG = 1'b0;
      end
      @(negedge CLK);
      t++;
    end
    TRIG = 1'b0;
  endtask

  // which: 0 = SI, 1 = LINE_DONE. Returns cycles elapsed, -1 on timeout.
  task automatic wait_for(input int which, input int bound, output int el);
    bit hit = 1'b0;
    el = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge CLK);
      if ((which == 0 && SI) || (which == 1 && LINE_DONE)) begin
        el  = i;
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_%s: no pulse within %0d cycles", (which == 0) ? "si" : "done", bound);
    end
  endtask

  task automatic restart(input logic fr, input logic [2:0] m, input int sl, input int ex);
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    FREE_RUN   = fr;
    COLOR_MASK = m;
    SLOT_LEN   = CNT_W'(sl);
    EXP_LEN    = CNT_W'(ex);
    ENABLE     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int el, ts, te, tsi, n1;
    bit bad;

    RST_N = 1'b0; ENABLE = 1'b0; FREE_RUN = 1'b0; TRIG = 1'b0;
    COLOR_MASK = 3'b000; SLOT_LEN = '0; EXP_LEN = '0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", 64'(obs()), 64'(0));
    RST_N = 1'b1;

    // Free-run line, mask 111, slot 10, exposure 4.
    add( 0, 0, 3'b100, 1, 0, 0, 0, 1, 0, 0);
    add( 1, 0, 3'b100, 0, 1, 0, 0, 1, 0, 0);
    add( 2, 0, 3'b100, 0, 0, 0, 0, 1, 0, 0);
    add( 5, 0, 3'b100, 0, 0, 1, 0, 1, 0, 0);
    add( 6, 0, 3'b100, 0, 0, 0, 0, 1, 0, 0);
    add( 9, 0, 3'b100, 0, 0, 0, 0, 1, 0, 0);
    add(10, 0, 3'b010, 1, 0, 0, 0, 1, 0, 0);
    add(11, 0, 3'b010, 0, 1, 0, 0, 1, 0, 0);
    add(15, 0, 3'b010, 0, 0, 1, 0, 1, 0, 0);
    add(20, 0, 3'b001, 1, 0, 0, 0, 1, 0, 0);
    add(21, 0, 3'b001, 0, 1, 0, 0, 1, 0, 0);
    add(25, 0, 3'b001, 0, 0, 1, 0, 1, 0, 0);
    add(29, 0, 3'b001, 0, 0, 0, 0, 1, 0, 0);
    add(30, 0, 3'b000, 0, 0, 0, 1, 1, 0, 1);
    add(31, 0, 3'b100, 1, 0, 0, 0, 1, 0, 1);
    n1 = vq.size();
    // Triggered lines, mask 101, slot 8, exposure 3, pending + overrun triggers.
    add( 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1);
    add( 1, 0, 3'b100, 1, 0, 0, 0, 1, 0, 1);
    add( 2, 0, 3'b100, 0, 1, 0, 0, 1, 0, 1);
    add( 4, 1, 3'b100, 0, 0, 0, 0, 1, 0, 1);
    add( 5, 0, 3'b100, 0, 0, 1, 0, 1, 0, 1);
    add( 7, 1, 3'b100, 0, 0, 0, 0, 1, 0, 1);
    add( 8, 0, 3'b100, 0, 0, 0, 0, 1, 1, 1);
    add( 9, 0, 3'b001, 1, 0, 0, 0, 1, 0, 1);
    add(10, 0, 3'b001, 0, 1, 0, 0, 1, 0, 1);
    add(13, 0, 3'b001, 0, 0, 1, 0, 1, 0, 1);
    add(16, 0, 3'b001, 0, 0, 0, 0, 1, 0, 1);
    add(17, 0, 3'b000, 0, 0, 0, 1, 1, 0, 2);
    add(18, 0, 3'b100, 1, 0, 0, 0, 1, 0, 2);
    add(26, 0, 3'b001, 1, 0, 0, 0, 1, 0, 2);
    add(34, 0, 3'b000, 0, 0, 0, 1, 1, 0, 3);
    add(35, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3);
    add(40, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3);

    restart(1'b1, 3'b111, 10, 4);
    wait_for(0, 10, el);
    check("first_launch_latency", 64'(el), 64'(2));
    run_seg("freerun", 0, n1 - 1);

    restart(1'b0, 3'b101, 8, 3);
    repeat (2) @(negedge CLK);
    run_seg("trig", n1, vq.size() - 1);

    // Slot clamped to EXP_LEN+2.
    restart(1'b1, 3'b110, 3, 5);
    wait_for(0, 10, el);
    ts = -1; te = -1; tsi = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (START && ts < 0)  ts  = i;
      if (END && te < 0)    te  = i;
      if (SI && tsi < 0)    tsi = i;
    end
    check("clamp_start", 64'(ts), 64'(1));
    check("clamp_end_spacing", 64'(te - ts), 64'(5));
    check("clamp_slot_len", 64'(tsi), 64'(7));

    // Zero exposure: no START/END, colour held for the slot.
    restart(1'b1, 3'b110, 5, 0);
    wait_for(0, 10, el);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (RGB != 3'b100 || START || END || !BUSY) bad = 1'b1;
      @(negedge CLK);
    end
    check("exp0_hold", 64'(bad), 64'(0));
    check("exp0_next_slot", 64'({SI, RGB}), 64'({1'b1, 3'b010}));

    // ENABLE dropped two cycles after START.
    restart(1'b1, 3'b111, 10, 6);
    wait_for(0, 10, el);
    @(negedge CLK);
    check("abort_start", 64'(START), 64'(1));
    repeat (2) @(negedge CLK);
    ENABLE = 1'b0;
    @(negedge CLK);
    check("abort_end", 64'({RGB, START, END, LINE_DONE, BUSY}),
          64'({3'b000, 1'b0, 1'b1, 1'b0, 1'b0}));
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (LINE_DONE || END || BUSY || SI || RGB != 3'b000) bad = 1'b1;
    end
    check("abort_quiet", 64'(bad), 64'(0));

    // Asynchronous reset in the middle of an exposure.
    restart(1'b1, 3'b111, 10, 4);
    wait_for(0, 10, el);
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 check("async_reset_outputs", 64'(obs()), 64'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    wait_for(0, 10, el);
    check("post_reset_setup", 64'({el[7:0], RGB, BUSY, LINE_CNT}),
          64'({8'd2, 3'b100, 1'b1, 16'd0}));
    wait_for(1, 40, el);
    check("post_reset_line", 64'({el[7:0], LINE_CNT}), 64'({8'd30, 16'd1}));

    // Empty mask parks in ARM; mask changes apply from the next line.
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    COLOR_MASK = 3'b000;
    ENABLE = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (SI || START || END || BUSY || LINE_DONE || RGB != 3'b000) bad = 1'b1;
    end
    check("mask0_parked", 64'(bad), 64'(0));
    COLOR_MASK = 3'b100;
    wait_for(0, 5, el);
    check("mask_launch", 64'({el[7:0], RGB}), 64'({8'd1, 3'b100}));
    COLOR_MASK = 3'b011;
    wait_for(1, 20, el);
    check("mask_shadow_done", 64'({el[7:0], LINE_CNT}), 64'({8'd10, 16'd2}));
    @(negedge CLK);
    check("mask_next_line_g", 64'({SI, RGB}), 64'({1'b1, 3'b010}));
    wait_for(0, 20, el);
    check("mask_next_line_b", 64'({el[7:0], RGB}), 64'({8'd10, 3'b001}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cis_line_sequencer.md
Name: cis_line_sequencer

Overview:
- Per-line colour sequencer for the contact-image-sensor front end; sits directly upstream of the RGB LED PWM driver.
- For each scan line it steps through the enabled colours in order R, G, B.
- Each colour gets one slot: a one-hot RGB select, a START/END-bounded exposure window, and a sensor SI pulse.
- Lines run free or are launched by an external trigger; LINE_DONE pulses after the last colour of each line.

Parameters:
- CNT_W, 32: width of the slot and exposure counters and their config inputs.
- LCNT_W, 16: width of the line counter.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- ENABLE  in  1  sequencer run enable (level).
- FREE_RUN  in  1  1 = back-to-back lines; 0 = each line waits for TRIG.
- TRIG  in  1  line trigger, single-cycle pulse.
- COLOR_MASK  in  3  enabled colours {R,G,B}.
- SLOT_LEN  in  CNT_W  clocks per colour slot.
- EXP_LEN  in  CNT_W  exposure clocks within a slot.
- START  out  1  exposure start pulse to the LED PWM driver.
- END  out  1  exposure end pulse to the LED PWM driver.
- RGB  out  3  one-hot colour select: 100=R, 010=G, 001=B, 000=none.
- SI  out  1  sensor line-start pulse.
- LINE_DONE  out  1  pulse after the last enabled slot of a line.
- BUSY  out  1  high while a line is in progress.
- OVERRUN  out  1  pulse when a trigger is dropped.
- LINE_CNT  out  LCNT_W  completed-line count, wraps.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; all outputs 0; LINE_CNT 0; pending-trigger flag cleared.
- States: IDLE, ARM, SETUP, EXPOSE, GAP.
- IDLE: go to ARM when ENABLE=1.
- ARM: line launches when COLOR_MASK!=0 and (FREE_RUN=1 or trigger pending or TRIG=1).
  - On launch, capture COLOR_MASK, SLOT_LEN, EXP_LEN into shadow registers; changes mid-line apply only to the next line.
  - Colour pointer is set to the first enabled colour in R, G, B order.
- SETUP: exactly 1 cycle.
  - RGB is driven to the current colour and SI pulses high for this cycle.
  - RGB is therefore valid one cycle before START, which covers the PWM driver's registered duty mux.
- EXPOSE:
  - START=1 in the first EXPOSE cycle.
  - END=1 exactly EXP_LEN cycles after START.
  - EXPOSE is left on the END cycle.
  - If EXP_LEN=0, EXPOSE is skipped entirely: no START and no END; the slot still elapses with RGB held.
- GAP: wait out the remainder of the slot.
  - Slot length measured from the SETUP cycle to the next SETUP cycle = max(SLOT_LEN, EXP_LEN+2) cycles.
  - At slot end, advance to the next enabled colour → SETUP.
  - If no enabled colour remains: LINE_DONE=1 for 1 cycle, LINE_CNT increments (wraps at 2^LCNT_W−1 → 0), RGB=000, return to ARM.
  - In free-run, the next SETUP follows ARM by 1 cycle.
- RGB: held for the whole slot (SETUP through GAP); 000 in IDLE and ARM.
- BUSY: 1 from SETUP of the first slot through the LINE_DONE cycle.
- Trigger handling:
  - TRIG while BUSY sets the pending flag (one deep).
  - TRIG while a trigger is already pending: OVERRUN pulses 1 cycle and the trigger is dropped.
  - TRIG in IDLE is ignored.
  - The pending flag clears on launch.
- ENABLE low mid-line:
  - If in EXPOSE, END is pulsed in the next cycle.
  - The FSM then goes to IDLE, RGB=000, pending flag cleared, no LINE_DONE.
- Simultaneous START and END are never generated, since EXP_LEN≥1 whenever START is issued.
- All outputs are registered.

Decomposition:
- Shared package:
  - state enum encoding;
  - colour one-hot constants RGB_R=3'b100, RGB_G=3'b010, RGB_B=3'b001;
  - CNT_W default.
- One natural sub-module: cis_color_ptr.
  - Next-enabled-colour selection from the mask and current colour.
  - Outputs: next colour and a last-colour flag.

Test Plan:
1. Free-run, mask=111, SLOT_LEN=10, EXP_LEN=4.
   - Expect SETUP at t=0,10,20 with RGB 100/010/001, and START at 1/11/21.
   - Expect END at 5/15/25, LINE_DONE at 30, LINE_CNT=1, next SETUP at 31.
2. Trigger mode, mask=101, SLOT_LEN=8, EXP_LEN=3.
   - Nothing happens until TRIG; then R and B slots only (G skipped), LINE_DONE 16 cycles after SETUP.
   - A second TRIG mid-line starts the next line right after ARM.
   - A third TRIG in the same line pulses OVERRUN.
3. SLOT_LEN=3, EXP_LEN=5: slot is clamped to 7 cycles, START→END spacing is 5.
   - EXP_LEN=0: no START/END pulses, RGB is held for SLOT_LEN cycles.
4. ENABLE dropped 2 cycles after START (EXP_LEN=6): END pulses the next cycle, RGB becomes 000, BUSY falls, no LINE_DONE.
5. RST_N asserted mid-EXPOSE: all outputs are 0 immediately (asynchronously). After release with ENABLE=1, the first line starts cleanly with LINE_CNT=0.
6. mask=000 with FREE_RUN=1: the FSM stays in ARM with no pulses. Changing the mask mid-line takes effect only on the following line.
